// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM between the core load/store
// unit (m0) and the debug/DMA port (m1). One access is granted per cycle and
// its response comes back one cycle later, tagged to the winner. Word indices
// at or above DP are flagged as out of range and never written.
//
// Build option: define RAM_ARB_RR_EN for round-robin conflict resolution.
// When it is undefined, m0 has fixed priority on a conflict.
module ram_arbiter #(
  parameter int DP = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_data_o,
  output logic        m0_err_o,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_data_o,
  output logic        m1_err_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic [3:0]  ram_sel_o,
  output logic        ram_we_o,
  input  logic [31:0] ram_data_i
);

  localparam logic [31:0] DP_L = 32'(DP);

  // Requester payloads gathered into arrays so both ports share one code path.
  logic [1:0]  req;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  sel   [2];
  logic [1:0]  we;
  logic [1:0]  in_range;

  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        rerr   [2];

  logic        win;      // 0 = m0, 1 = m1; defaults to m0 when idle
  logic        granted;  // some access is accepted this cycle

  logic        last_q;
  logic        rvalid_q;
  logic        rid_q;
  logic        err_q;
  logic        we_q;

  assign req      = {m1_req_i, m0_req_i};
  assign addr[0]  = m0_addr_i;
  assign addr[1]  = m1_addr_i;
  assign wdata[0] = m0_data_i;
  assign wdata[1] = m1_data_i;
  assign sel[0]   = m0_sel_i;
  assign sel[1]   = m1_sel_i;
  assign we       = {m1_we_i, m0_we_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // Full-width compare: indices past DP are errors, never wrapped.
      assign in_range[gi] = ({2'b00, addr[gi][31:2]} < DP_L);

      // Response only reaches the port that owned the pending access.
      assign rvalid[gi] = rvalid_q & (rid_q == (gi != 0));
      assign rdata[gi]  = (rvalid[gi] && !we_q && !err_q) ? ram_data_i : 32'h0;
      assign rerr[gi]   = rvalid[gi] & err_q;
    end
  endgenerate

  // Pick the winner of this cycle; a lone requester always wins.
  always_comb begin
    win = 1'b0;
`ifdef RAM_ARB_RR_EN
    if (req[0] && req[1]) begin
      win = ~last_q;
    end else begin
      win = req[1];
    end
`else
    win = req[1] & ~req[0];
`endif
  end

`ifndef RAM_ARB_RR_EN
  // last_q is still tracked in fixed-priority builds but has no reader.
  logic unused_last;
  assign unused_last = last_q;
`endif

  // Grants are gated by reset so everything drops the moment rst_n falls.
  assign granted  = (req[0] | req[1]) & rst_n;
  assign m0_gnt_o = granted & ~win;
  assign m1_gnt_o = granted & win;

  assign ram_addr_o = addr[win];
  assign ram_data_o = wdata[win];
  assign ram_sel_o  = sel[win];
  assign ram_we_o   = granted & we[win] & in_range[win];

  assign m0_rvalid_o = rvalid[0];
  assign m0_data_o   = rdata[0];
  assign m0_err_o    = rerr[0];
  assign m1_rvalid_o = rvalid[1];
  assign m1_data_o   = rdata[1];
  assign m1_err_o    = rerr[1];

  // Capture the granted access so its response is returned next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      rvalid_q <= 1'b0;
      rid_q    <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      rvalid_q <= granted;
      if (granted) begin
        last_q <= win;
        rid_q  <= win;
        err_q  <= ~in_range[win];
        we_q   <= we[win];
      end
    end
  end

endmodule
